clarke_park: RTL and testbench

Feedback-path transform for the field-oriented current loop. It samples two measured phase currents and the electrical angle, then applies the Clarke transform (a,b → α,β). It then applies the forward Park transform (α,β → d,q) with an iterative CORDIC rotator, and delivers signed Id/Iq with a one-cycle done strobe. It sits between the ADC sampling logic and the d/q current regulators, the inverse of the inverse-Park/SVPWM drive path.

---
 rtl/clarke_park_if.sv | 22 ++
 rtl/clarke_park.sv | 184 ++++++++++++++++++
 tb/tb_clarke_park.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clarke_park_if.sv
// clarke_park_if: start strobe, phase currents and angle into the
// Clarke/Park block, d/q currents and status back out.
interface clarke_park_if;
    logic               iCP_en;
    logic signed [15:0] iIa;
    logic signed [15:0] iIb;
    logic        [19:0] iTheta;
    logic signed [15:0] oId;
    logic signed [15:0] oIq;
    logic               oCP_done;
    logic               oBusy;

    modport master (
        output iCP_en, iIa, iIb, iTheta,
        input  oId, oIq, oCP_done, oBusy
    );

    modport slave (
        input  iCP_en, iIa, iIb, iTheta,
        output oId, oIq, oCP_done, oBusy
    );
endinterface

// File: rtl/clarke_park.sv
// clarke_park: feedback-path transform for the FOC current loop.
// Latches Ia/Ib/theta, applies the Clarke transform, then rotates
// (alpha,beta) by -theta with a 16-step iterative CORDIC and removes the
// CORDIC gain, delivering signed Id/Iq with a one-cycle done strobe.
// Optional build macro: CP_SATURATE_EN clamps results to 16-bit range
// instead of taking the low 16 bits.
module clarke_park (
    input  logic         iClk,
    input  logic         iRst,
    clarke_park_if.slave cp
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLARKE,
        S_PREROT,
        S_ITER,
        S_GAIN,
        S_DONE
    } state_t;

    // 2^16/sqrt(3) and 2^16/K (K = CORDIC gain for 16 steps)
    localparam logic signed [16:0] INV_SQRT3_K = 17'sd37837;
    localparam logic signed [16:0] INV_GAIN_K  = 17'sd39797;

    // atan(2^-i) in units of 2^20 per full turn
    localparam logic signed [20:0] ATAN_LUT [16] = '{
        21'sd131072, 21'sd77376, 21'sd40884, 21'sd20753,
        21'sd10417,  21'sd5214,  21'sd2608,  21'sd1304,
        21'sd652,    21'sd326,   21'sd163,   21'sd81,
        21'sd41,     21'sd20,    21'sd10,    21'sd5
    };

    state_t             state_reg;
    logic signed [15:0] ia_reg;
    logic signed [15:0] ib_reg;
    logic        [19:0] theta_reg;
    logic signed [19:0] x_reg;
    logic signed [19:0] y_reg;
    logic signed [20:0] z_reg;
    logic        [3:0]  iter_reg;
    logic signed [15:0] id_reg;
    logic signed [15:0] iq_reg;
    logic               done_reg;
    logic               busy_reg;

    // Clarke beta: (Ia + 2*Ib) * 37837 >>> 16 on an 18-bit sum
    logic signed [17:0] clarke_sum;
    logic signed [34:0] clarke_prod;
    logic signed [19:0] clarke_alpha;
    logic signed [19:0] clarke_beta;

    assign clarke_sum   = {{2{ia_reg[15]}}, ia_reg} + {ib_reg[15], ib_reg, 1'b0};
    assign clarke_prod  = clarke_sum * INV_SQRT3_K;
    assign clarke_alpha = {{4{ia_reg[15]}}, ia_reg};
    assign clarke_beta  = 20'(clarke_prod >>> 16);

    // All arithmetic shifts of x/y, selected by the iteration index
    logic signed [19:0] x_sh [16];
    logic signed [19:0] y_sh [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_shift
        assign x_sh[gi] = x_reg >>> gi;
        assign y_sh[gi] = y_reg >>> gi;
    end

    logic signed [19:0] x_step;
    logic signed [19:0] y_step;
    logic signed [20:0] atan_step;

    assign x_step    = x_sh[iter_reg];
    assign y_step    = y_sh[iter_reg];
    assign atan_step = ATAN_LUT[iter_reg];

    // Gain compensation products, kept at 20 bits after the shift
    logic signed [36:0] gain_x_prod;
    logic signed [36:0] gain_y_prod;
    logic signed [19:0] gain_x;
    logic signed [19:0] gain_y;

    assign gain_x_prod = x_reg * INV_GAIN_K;
    assign gain_y_prod = y_reg * INV_GAIN_K;
    assign gain_x      = 20'(gain_x_prod >>> 16);
    assign gain_y      = 20'(gain_y_prod >>> 16);

`ifdef CP_SATURATE_EN
    function automatic logic signed [15:0] clamp16(input logic signed [19:0] v);
        if (v > 20'sd32767) begin
            return 16'sh7fff;
        end else if (v < -20'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction
`endif

    // Control FSM and datapath; x/y are reused for alpha/beta and for the
    // gain-compensated results so the output registers only load in DONE.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg <= S_IDLE;
            ia_reg    <= '0;
            ib_reg    <= '0;
            theta_reg <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_reg  <= '0;
            id_reg    <= '0;
            iq_reg    <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // Busy trails the state by one edge: rises one edge after the
            // start is sampled and falls one edge after DONE.
            busy_reg <= (state_reg != S_IDLE);
            case (state_reg)
                S_IDLE: begin
                    if (cp.iCP_en) begin
                        ia_reg    <= cp.iIa;
                        ib_reg    <= cp.iIb;
                        theta_reg <= cp.iTheta;
                        state_reg <= S_CLARKE;
                    end
                end
                S_CLARKE: begin
                    x_reg     <= clarke_alpha;
                    y_reg     <= clarke_beta;
                    state_reg <= S_PREROT;
                end
                S_PREROT: begin
                    // Quarter-turn pre-rotation by -90 deg * quadrant
                    case (theta_reg[19:18])
                        2'd0: begin x_reg <= x_reg;  y_reg <= y_reg;  end
                        2'd1: begin x_reg <= y_reg;  y_reg <= -x_reg; end
                        2'd2: begin x_reg <= -x_reg; y_reg <= -y_reg; end
                        default: begin x_reg <= -y_reg; y_reg <= x_reg; end
                    endcase
                    z_reg     <= {3'b000, theta_reg[17:0]};
                    iter_reg  <= 4'd0;
                    state_reg <= S_ITER;
                end
                S_ITER: begin
                    if (!z_reg[20]) begin
                        x_reg <= x_reg + y_step;
                        y_reg <= y_reg - x_step;
                        z_reg <= z_reg - atan_step;
                    end else begin
                        x_reg <= x_reg - y_step;
                        y_reg <= y_reg + x_step;
                        z_reg <= z_reg + atan_step;
                    end
                    iter_reg <= iter_reg + 4'd1;
                    if (iter_reg == 4'd15) begin
                        state_reg <= S_GAIN;
                    end
                end
                S_GAIN: begin
                    x_reg     <= gain_x;
                    y_reg     <= gain_y;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
`ifdef CP_SATURATE_EN
                    id_reg <= clamp16(x_reg);
                    iq_reg <= clamp16(y_reg);
`else
                    id_reg <= x_reg[15:0];
                    iq_reg <= y_reg[15:0];
`endif
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cp.oId      = id_reg;
    assign cp.oIq      = iq_reg;
    assign cp.oCP_done = done_reg;
    assign cp.oBusy    = busy_reg;
endmodule

// File: tb/tb_clarke_park.sv
// tb_clarke_park: scoreboard bench for clarke_park. Stimulus pushes the
// expected Id/Iq (fixed-point transform model plus an ideal real-valued
// transform for the directed cases) and the expected done cycle; a monitor
// pops and compares on every oCP_done and checks outputs hold otherwise.
module tb_clarke_park;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clarke_park_if cp_if ();

    clarke_park dut (
        .iClk (clk),
        .iRst (rst),
        .cp   (cp_if)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int q;
        int d_ideal;
        int q_ideal;
        bit use_ideal;
        int done_cyc;
        int tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag_n = 0;

    int atan_tab [16] = '{131072, 77376, 40884, 20753, 10417, 5214, 2608, 1304,
                          652, 326, 163, 81, 41, 20, 10, 5};

    function automatic int reduce16(input longint v);
`ifdef CP_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
`else
        return int'(shortint'(v));
`endif
    endfunction

    // Fixed-point transform as a plain algorithm: Clarke, quadrant fold,
    // 16 CORDIC micro-rotations, gain removal.
    function automatic void model(input int ia, input int ib, input int th,
                                  output int d, output int q);
        longint al, be, x, y, z, xn, yn;
        int quad;
        al = ia;
        be = (longint'(ia + 2 * ib) * 37837) >>> 16;
        quad = (th >> 18) & 3;
        z = th & 32'h3FFFF;
        case (quad)
            0: begin x = al;  y = be;  end
            1: begin x = be;  y = -al; end
            2: begin x = -al; y = -be; end
            default: begin x = -be; y = al; end
        endcase
        for (int i = 0; i < 16; i++) begin
            if (z >= 0) begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = z - atan_tab[i];
            end else begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = z + atan_tab[i];
            end
            x = xn;
            y = yn;
        end
        d = reduce16((x * 39797) >>> 16);
        q = reduce16((y * 39797) >>> 16);
    endfunction

    function automatic int rnd(input real v);
        return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    endfunction

    // Ideal real-valued Clarke + rotation by -theta
    function automatic void ideal(input int ia, input int ib, input int th,
                                  output int d, output int q);
        real a, b, t;
        a = ia;
        b = (ia + 2.0 * ib) / $sqrt(3.0);
        t = th * 2.0 * 3.14159265358979 / 1048576.0;
        d = reduce16(rnd(a * $cos(t) + b * $sin(t)));
        q = reduce16(rnd(-a * $sin(t) + b * $cos(t)));
    endfunction

    task automatic check(input string nm, input int act, input int req, input int tag);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s tag=%0d got=%0d want=%0d", nm, tag, act, req);
        end
    endtask

    task automatic check_tol(input string nm, input int act, input int req, input int tag);
        int diff;
        total++;
        diff = act - req;
        if (diff > 3 || diff < -3) begin
            bad++;
            $display("FAIL %s tag=%0d got=%0d want=%0d+-3", nm, tag, act, req);
        end
    endtask

    // Called at a negedge; the following posedge is edge 0 of the transform.
    task automatic start_tx(input int ia, input int ib, input int th, input bit use_ideal);
        exp_t e;
        model(ia, ib, th, e.d, e.q);
        ideal(ia, ib, th, e.d_ideal, e.q_ideal);
        e.use_ideal = use_ideal;
        e.done_cyc  = cyc + 21;
        e.tag       = tag_n++;
        sb_q.push_back(e);
        cp_if.iCP_en = 1'b1;
        cp_if.iIa    = 16'(ia);
        cp_if.iIb    = 16'(ib);
        cp_if.iTheta = 20'(th);
        @(negedge clk);
        cp_if.iCP_en = 1'b0;
        cp_if.iIa    = 16'($urandom);
        cp_if.iIb    = 16'($urandom);
        cp_if.iTheta = 20'($urandom);
        $display("tx tag=%0d ia=%0d ib=%0d th=%0d exp_d=%0d exp_q=%0d",
                 e.tag, ia, ib, th, e.d, e.q);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout pending=%0d cyc=%0d", sb_q.size(), cyc);
            sb_q.delete();
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge
    initial begin : monitor
        exp_t e;
        bit skip;
        logic signed [15:0] pid, piq;
        skip = 1'b1;
        pid  = '0;
        piq  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                skip = 1'b1;
            end else if (skip) begin
                skip = 1'b0;
            end else if (cp_if.oCP_done) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done cyc=%0d id=%0d iq=%0d", cyc, cp_if.oId, cp_if.oIq);
                end else begin
                    e = sb_q.pop_front();
                    check("done_cycle", cyc, e.done_cyc, e.tag);
                    check("id_exact", cp_if.oId, e.d, e.tag);
                    check("iq_exact", cp_if.oIq, e.q, e.tag);
                    if (e.use_ideal) begin
                        check_tol("id_ideal", cp_if.oId, e.d_ideal, e.tag);
                        check_tol("iq_ideal", cp_if.oIq, e.q_ideal, e.tag);
                    end
                    $display("rx tag=%0d cyc=%0d id=%0d iq=%0d", e.tag, cyc, cp_if.oId, cp_if.oIq);
                end
            end else begin
                total++;
                if (cp_if.oId !== pid || cp_if.oIq !== piq) begin
                    bad++;
                    $display("FAIL hold cyc=%0d id=%0d/%0d iq=%0d/%0d", cyc, cp_if.oId, pid, cp_if.oIq, piq);
                end
            end
            pid = cp_if.oId;
            piq = cp_if.oIq;
        end
    end

    initial begin : stimulus
        int e0;
        int ia, ib, th;
        rst          = 1'b1;
        cp_if.iCP_en = 1'b0;
        cp_if.iIa    = '0;
        cp_if.iIb    = '0;
        cp_if.iTheta = '0;
        repeat (3) @(negedge clk);
        check("rst_id", cp_if.oId, 0, -1);
        check("rst_iq", cp_if.oIq, 0, -1);
        check("rst_done", int'(cp_if.oCP_done), 0, -1);
        check("rst_busy", int'(cp_if.oBusy), 0, -1);
        rst = 1'b0;
        @(negedge clk);

        // Directed: theta=0 with busy timing
        start_tx(10000, -5000, 0, 1'b1);
        e0 = cyc;
        check("busy_e0", int'(cp_if.oBusy), 0, 0);
        wait_until(e0 + 1);
        check("busy_e1", int'(cp_if.oBusy), 1, 0);
        wait_until(e0 + 19);
        check("done_e19", int'(cp_if.oCP_done), 0, 0);
        wait_until(e0 + 20);
        check("busy_e20", int'(cp_if.oBusy), 1, 0);
        wait_until(e0 + 21);
        check("busy_e21", int'(cp_if.oBusy), 0, 0);
        check("done_e21", int'(cp_if.oCP_done), 0, 0);
        wait_idle();

        start_tx(10000, -5000, 262144, 1'b1);
        wait_idle();
        start_tx(10000, -5000, 786432, 1'b1);
        wait_idle();
        start_tx(0, 10000, 0, 1'b1);
        wait_idle();
        start_tx(32767, 32767, 174763, 1'b1);
        wait_idle();

        // Throughput: pulses at edges 5 and 20 ignored, edge 21 accepted
        start_tx(1234, -4321, 100000, 1'b1);
        e0 = cyc;
        wait_until(e0 + 4);
        cp_if.iCP_en = 1'b1;
        @(negedge clk);
        cp_if.iCP_en = 1'b0;
        wait_until(e0 + 19);
        cp_if.iCP_en = 1'b1;
        @(negedge clk);
        start_tx(-20000, 7000, 600000, 1'b0);
        wait_idle();

        // Reset mid-transform
        start_tx(-7000, 3000, 500000, 1'b0);
        e0 = cyc;
        wait_until(e0 + 10);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_id", cp_if.oId, 0, -2);
        check("midrst_iq", cp_if.oIq, 0, -2);
        check("midrst_done", int'(cp_if.oCP_done), 0, -2);
        check("midrst_busy", int'(cp_if.oBusy), 0, -2);
        rst = 1'b0;
        sb_q.delete();
        repeat (30) @(negedge clk);
        start_tx(15000, -2500, 400000, 1'b1);
        wait_idle();

        // Randomized transforms over the full input range
        for (int k = 0; k < 40; k++) begin
            ia = int'(shortint'($urandom));
            ib = int'(shortint'($urandom));
            th = int'($urandom_range(0, 1048575));
            start_tx(ia, ib, th, 1'b0);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover pending=%0d", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
